// File: rtl/waterfall_led_ctrl.sv
// waterfall_led_ctrl: LED_W-bit waterfall light engine with four patterns
// (rotate left, rotate right, ping-pong, bar fill) stepped by a runtime
// programmable prescaler (step period = div+1 clk cycles).
// Optional build macro ACTIVE_LOW_LED_EN: when defined the led port drives
// the inverse of the internal pattern for active-low LED boards.
module waterfall_led_ctrl #(
    parameter int LED_W = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [LED_W-1:0] led,
    output logic             step_pulse
);

    typedef enum logic {DIR_UP, DIR_DN} dir_t;

    localparam logic [LED_W-1:0] ONE = LED_W'(1);
    localparam logic [LED_W-1:0] MSB = {1'b1, {(LED_W-1){1'b0}}};

    logic [LED_W-1:0] pat, pat_nxt, step_pat;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [1:0]       mode_q;
    dir_t             dir, dir_nxt, step_dir;
    logic             pulse_nxt;
    logic             onehot;
    logic             go_up;

    // Pattern shown when a mode is entered (also the self-recovery target).
    function automatic logic [LED_W-1:0] entry_pat(input logic [1:0] m);
        case (m)
            2'd1:    entry_pat = MSB;
            2'd3:    entry_pat = '0;
            default: entry_pat = ONE;
        endcase
    endfunction

    // Next pattern/direction for one step of the current mode.
    always_comb begin
        step_pat = pat;
        step_dir = dir;
        go_up    = 1'b1;
        onehot   = (pat != '0) && ((pat & (pat - ONE)) == '0);
        case (mode_q)
            2'd0: step_pat = {pat[LED_W-2:0], pat[LED_W-1]};
            2'd1: step_pat = {pat[0], pat[LED_W-1:1]};
            2'd2: begin
                // Endpoints force the direction so a stale dir cannot
                // shift the single one off the end of the bank.
                go_up    = pat[0] ? 1'b1 : (pat[LED_W-1] ? 1'b0 : (dir == DIR_UP));
                step_pat = go_up ? (pat << 1) : (pat >> 1);
                step_dir = step_pat[LED_W-1] ? DIR_DN : (step_pat[0] ? DIR_UP : dir);
            end
            default: step_pat = (&pat) ? '0 : {pat[LED_W-2:0], 1'b1};
        endcase
        // Corrupted one-hot state in the moving-dot modes restarts the mode.
        if (mode_q != 2'd3 && !onehot) begin
            step_pat = entry_pat(mode_q);
            step_dir = DIR_UP;
        end
    end

    // Prescaler and mode-change sequencing; a mode change beats a tick.
    always_comb begin
        pat_nxt   = pat;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        if (mode != mode_q) begin
            pat_nxt = entry_pat(mode);
            dir_nxt = DIR_UP;
            cnt_nxt = '0;
        end else if (en) begin
            if (cnt == div) begin
                pat_nxt   = step_pat;
                dir_nxt   = step_dir;
                cnt_nxt   = '0;
                pulse_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + DIV_W'(1);
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat        <= ONE;
            dir        <= DIR_UP;
            cnt        <= '0;
            mode_q     <= 2'd0;
            step_pulse <= 1'b0;
        end else begin
            pat        <= pat_nxt;
            dir        <= dir_nxt;
            cnt        <= cnt_nxt;
            mode_q     <= mode;
            step_pulse <= pulse_nxt;
        end
    end

`ifdef ACTIVE_LOW_LED_EN
    assign led = ~pat;
`else
    assign led = pat;
`endif

endmodule

// File: tb/tb_waterfall_led_ctrl.sv
// Self-checking bench for waterfall_led_ctrl: three widths (8, 2, 16) share
// one stimulus stream and are checked every cycle against a step-index model.
module tb_waterfall_led_ctrl;

    localparam int DIV_W = 24;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [7:0]        led8;
    logic [1:0]        led2;
    logic [15:0]       led16;
    logic              sp8, sp2, sp16;

    int checks   = 0;
    int failures = 0;

    // Reference model: the pattern is a pure function of (mode, step index k).
    longint m_cnt;
    int     m_mq, m_k;
    logic   m_pulse;

`ifdef ACTIVE_LOW_LED_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    waterfall_led_ctrl #(.LED_W(8),  .DIV_W(DIV_W)) u8  (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led8),  .step_pulse(sp8));
    waterfall_led_ctrl #(.LED_W(2),  .DIV_W(DIV_W)) u2  (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led2),  .step_pulse(sp2));
    waterfall_led_ctrl #(.LED_W(16), .DIV_W(DIV_W)) u16 (.clk(clk), .rst(rst), .en(en), .mode(mode), .div(div), .led(led16), .step_pulse(sp16));

    always #5 clk = ~clk;

    function automatic longint pat_of(int m, int k, int w);
        int p;
        case (m)
            0: return longint'(1) << (k % w);
            1: return longint'(1) << (w - 1 - (k % w));
            2: begin
                p = k % (2 * w - 2);
                return longint'(1) << ((p < w) ? p : (2 * w - 2 - p));
            end
            default: begin
                p = k % (w + 1);
                return (longint'(1) << p) - 1;
            end
        endcase
    endfunction

    function automatic logic [31:0] exp_led(int w);
        longint mask = (longint'(1) << w) - 1;
        longint v = pat_of(m_mq, m_k, w);
        if (INV) v = ~v;
        return 32'(v & mask);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: the model consumes the inputs present at the edge.
    task automatic cyc();
        logic r = rst, e = en;
        int m = mode;
        longint d = div;
        @(posedge clk);
        #1;
        if (r) begin
            m_cnt = 0; m_mq = 0; m_k = 0; m_pulse = 1'b0;
        end else if (m != m_mq) begin
            m_mq = m; m_k = 0; m_cnt = 0; m_pulse = 1'b0;
        end else if (e) begin
            if (m_cnt == d) begin
                m_k++; m_cnt = 0; m_pulse = 1'b1;
            end else begin
                m_cnt = (m_cnt + 1) % (longint'(1) << DIV_W);
                m_pulse = 1'b0;
            end
        end else begin
            m_pulse = 1'b0;
        end
        chk("led_w8",  32'(led8),  exp_led(8));
        chk("led_w2",  32'(led2),  exp_led(2));
        chk("led_w16", 32'(led16), exp_led(16));
        chk("pulse_w8",  32'(sp8),  32'(m_pulse));
        chk("pulse_w2",  32'(sp2),  32'(m_pulse));
        chk("pulse_w16", 32'(sp16), 32'(m_pulse));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        m_cnt = 0; m_mq = 0; m_k = 0; m_pulse = 1'b0;
        // Reset with the prescaler already configured.
        rst = 1'b1; en = 1'b1; mode = 2'd0; div = 24'd3;
        run(3);
        chk("reset_led_w8",  32'(led8),  INV ? 32'hFE : 32'h01);
        chk("reset_led_w16", 32'(led16), INV ? 32'hFFFE : 32'h0001);
        rst = 1'b0;
        run(3);
        chk("before_first_step", 32'(led8), INV ? 32'hFE : 32'h01);
        run(1);
        chk("first_step", 32'(led8), INV ? 32'hFD : 32'h02);
        chk("first_step_pulse", 32'(sp8), 32'h1);
        run(6);
        // Rotate left at full rate, then rotate right.
        rst = 1'b1; div = 24'd0; run(1); rst = 1'b0;
        run(10);
        mode = 2'd1; run(1);
        chk("rotr_entry", 32'(led8), INV ? 32'h7F : 32'h80);
        chk("rotr_entry_pulse", 32'(sp8), 32'h0);
        run(10);
        // Ping-pong with a two-cycle step.
        mode = 2'd2; div = 24'd1; run(42);
        // Bar fill at full rate.
        mode = 2'd3; div = 24'd0; run(12);
        // Freeze mid-sequence, mode change while frozen, resume.
        mode = 2'd0; div = 24'd2; run(13);
        chk("freeze_point", 32'(led8), INV ? 32'hEF : 32'h10);
        en = 1'b0; run(50);
        chk("frozen_hold", 32'(led8), INV ? 32'hEF : 32'h10);
        mode = 2'd1; run(5);
        chk("frozen_mode_entry", 32'(led8), INV ? 32'h7F : 32'h80);
        en = 1'b1; run(10);
        // Randomized phase; div only changes together with a reset or a
        // mode change so the counter never has to wrap through 2^DIV_W.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                mode = 2'($urandom_range(0, 3));
                if (int'(mode) != m_mq) div = DIV_W'($urandom_range(0, 3));
            end
            if (rst) div = DIV_W'($urandom_range(0, 3));
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/waterfall_led_ctrl.md
Name: waterfall_led_ctrl

Overview:
Parametrised waterfall-light engine driving an LED_W-bit LED bank from a single system clock. It provides four selectable patterns: rotate left, rotate right, ping-pong and bar fill. Step rate is set at runtime by a programmable prescaler. It replaces the fixed 8-bit shift-only LED driver on the GPIO path and sits directly between the board clock and the LED pins.

Parameters:
LED_W, 8, number of LEDs driven; legal range 2..32.
DIV_W, 24, width of the prescaler counter and of the div input.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = prescaler runs and pattern advances; 0 = freeze
mode  input  2  0 rotate-left, 1 rotate-right, 2 ping-pong, 3 fill
div  input  DIV_W  step period minus one, in clk cycles
led  output  LED_W  LED drive pattern, registered
step_pulse  output  1  one-cycle strobe, high in the cycle led shows a new step

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values: led = 1 (bit 0 only); step_pulse = 0; cnt = 0; mode_q = 0; dir = up.
- Prescaler:
  - When en = 1: if cnt == div, then tick, and cnt <= 0. Otherwise cnt <= cnt + 1.
  - Step period is div+1 cycles. div = 0 gives a tick every cycle.
  - When en = 0: cnt, led and dir hold, and step_pulse = 0.
  - If div is lowered below the current cnt, cnt continues to 2^DIV_W-1, wraps to 0 and then matches. No special handling.
- On tick, led and step_pulse update on the same edge. step_pulse = 1 for exactly that one cycle. Latency from cnt==div to the new led value is 1 edge.
- Mode change:
  - mode is registered into mode_q every cycle, including when en = 0.
  - When mode != mode_q, the next edge loads the entry pattern of the new mode, clears cnt, sets dir = up and sets step_pulse = 0.
  - This reinit has priority over a simultaneous tick.
- Entry patterns: mode 0 = 0x..01; mode 1 = MSB only; mode 2 = 0x..01 with dir = up; mode 3 = all zeros.
- Step rules per mode:
  - 0: led <= {led[LED_W-2:0], led[LED_W-1]}.
  - 1: led <= {led[0], led[LED_W-1:1]}.
  - 2: a single one moves up while dir = up, and down while dir = down.
    - On the step that places the one at the MSB, dir flips to down. On the step that places it at bit 0, dir flips to up.
    - Endpoints are never shown twice in a row. LED_W=8 sequence: 01 02 04 08 10 20 40 80 40 20 ... 02 01 02.
  - 3: if led is all ones, led <= 0; otherwise led <= {led[LED_W-2:0], 1'b1}. LED_W=8 sequence: 00 01 03 07 0F 1F 3F 7F FF 00.
- Illegal or corrupted state: in modes 0, 1 and 2, if led holds no ones or more than one one, the next tick loads the entry pattern (self-recovery).
- Reset has priority over everything. Reset asserted mid-step returns to the reset values on that edge regardless of en or mode.

Optional Feature:
ACTIVE_LOW_LED_EN
- Defined: the led port drives the bitwise inverse of the internal pattern, for boards with active-low LEDs. The reset value on the port is then ~1 (e.g. 8'hFE). step_pulse is unchanged.
- Not defined: the led port equals the internal pattern (active-high), as described above.

Test Plan:
1. Reset: rst=1 for 3 cycles with en=1, mode=0, div=3 -> led=8'h01, step_pulse=0 throughout; after release, first led change (8'h02) occurs 4 cycles later with step_pulse=1 for that cycle only.
2. Rotate left/right with div=0, en=1: mode 0 gives 01,02,...,80,01 on consecutive cycles. Switching to mode 1 gives 80 on the next edge with step_pulse=0, then 40,20,... each cycle.
3. Ping-pong, div=1, 20 steps -> led 01,02,...,80,40,...,01,02 with no repeated endpoint; step_pulse every 2nd cycle.
4. Fill, div=0 -> 00,01,03,07,0F,1F,3F,7F,FF,00 across 10 consecutive steps.
5. Freeze: en=0 for 50 cycles mid-sequence at led=8'h10 -> led holds 8'h10, step_pulse=0. Change mode during the freeze -> entry pattern loaded even while frozen. With en=1 again, the step resumes after div+1 cycles.
6. Parameter and macro sweep: LED_W=2 and LED_W=16 with all four modes, and a build with ACTIVE_LOW_LED_EN -> led equals the inverted expected pattern (reset 16'hFFFE for LED_W=16).
